mem_writeback: RTL and testbench

MEM_WRITEBACK -- requirements
Module: mem_writeback

---
 rtl/mem_writeback.sv | 154 +++++++++++++++
 tb/tb_mem_writeback.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_writeback.sv
// Memory and writeback stages of a 5-stage pipeline.
//
// Purpose: registers execute-stage results into the M register, drives a
// request/acknowledge data-memory port with a bounded wait, and registers the
// final result into the W register for the register-file write port.
//
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   *_e_i                      execute-stage controls, ALU result, store data, dest reg
//   dmem_req_o/we_o/addr_o/wdata_o, dmem_ack_i/rdata_i   data-memory port
//   alu_out_m_o, reg_write_m_o, write_reg_m_o, mem_to_reg_m_o   M register contents
//   stall_m_o                  memory stage busy, upstream stages hold
//   reg_write_w_o, write_reg_w_o, result_w_o   W register contents
//   misalign_o, bus_err_o      one-cycle fault pulses
module mem_writeback #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        reg_write_e_i,
  input  logic        mem_write_e_i,
  input  logic        mem_to_reg_e_i,
  input  logic [31:0] alu_out_e_i,
  input  logic [31:0] write_data_e_i,
  input  logic [4:0]  write_reg_e_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [31:0] alu_out_m_o,
  output logic        reg_write_m_o,
  output logic [4:0]  write_reg_m_o,
  output logic        mem_to_reg_m_o,
  output logic        stall_m_o,
  output logic        reg_write_w_o,
  output logic [4:0]  write_reg_w_o,
  output logic [31:0] result_w_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  localparam logic [7:0] CntLast = 8'(TIMEOUT_CYCLES - 1);

  // M register
  logic        r_reg_write_m;
  logic        r_mem_write_m;
  logic        r_mem_to_reg_m;
  logic [31:0] r_alu_out_m;
  logic [31:0] r_write_data_m;
  logic [4:0]  r_write_reg_m;

  // W register
  logic        r_reg_write_w;
  logic [4:0]  r_write_reg_w;
  logic [31:0] r_result_w;

  state_e      r_state;
  logic [7:0]  r_cnt;

  logic w_mem_op;
  logic w_aligned;
  logic w_req;
  logic w_timeout;
  logic w_misalign;
  logic w_stall;
  logic w_fault;

  always_comb begin
    w_mem_op   = r_mem_write_m | r_mem_to_reg_m;
    w_aligned  = (r_alu_out_m[1:0] == 2'b00);
    // The FSM only has IDLE and WAIT, so every aligned memory op requests.
    w_req      = w_mem_op & w_aligned;
    w_timeout  = (r_state == StWait) & (r_cnt == CntLast) & ~dmem_ack_i;
    w_misalign = w_mem_op & ~w_aligned;
    // Abort cycle releases the stall so M advances past the failed access.
    w_stall    = w_req & ~dmem_ack_i & ~w_timeout;
    w_fault    = w_misalign | w_timeout;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_reg_write_m  <= 1'b0;
      r_mem_write_m  <= 1'b0;
      r_mem_to_reg_m <= 1'b0;
      r_alu_out_m    <= 32'h0;
      r_write_data_m <= 32'h0;
      r_write_reg_m  <= 5'h0;
    end else if (!w_stall) begin
      r_reg_write_m  <= reg_write_e_i;
      r_mem_write_m  <= mem_write_e_i;
      r_mem_to_reg_m <= mem_to_reg_e_i;
      r_alu_out_m    <= alu_out_e_i;
      r_write_data_m <= write_data_e_i;
      r_write_reg_m  <= write_reg_e_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= StIdle;
      r_cnt   <= 8'h0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_req && !dmem_ack_i) begin
            r_state <= StWait;
            r_cnt   <= 8'h0;
          end
        end
        StWait: begin
          if (!w_req || dmem_ack_i || w_timeout) begin
            r_state <= StIdle;
          end else begin
            r_cnt <= r_cnt + 8'h1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Stores never write the register file, even if reg_write is set with them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_reg_write_w <= 1'b0;
      r_write_reg_w <= 5'h0;
      r_result_w    <= 32'h0;
    end else begin
      r_reg_write_w <= r_reg_write_m & ~r_mem_write_m & ~w_stall & ~w_fault;
      r_write_reg_w <= r_write_reg_m;
      r_result_w    <= r_mem_to_reg_m ? dmem_rdata_i : r_alu_out_m;
    end
  end

  assign dmem_req_o     = w_req;
  assign dmem_we_o      = r_mem_write_m;
  assign dmem_addr_o    = r_alu_out_m;
  assign dmem_wdata_o   = r_write_data_m;
  assign stall_m_o      = w_stall;
  assign misalign_o     = w_misalign;
  assign bus_err_o      = w_timeout;
  assign alu_out_m_o    = r_alu_out_m;
  assign reg_write_m_o  = r_reg_write_m;
  assign write_reg_m_o  = r_write_reg_m;
  assign mem_to_reg_m_o = r_mem_to_reg_m;
  assign reg_write_w_o  = r_reg_write_w;
  assign write_reg_w_o  = r_write_reg_w;
  assign result_w_o     = r_result_w;

endmodule

// File: tb/tb_mem_writeback.sv
module tb_mem_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_write_e, mem_write_e, mem_to_reg_e;
  logic [31:0] alu_out_e, write_data_e;
  logic [4:0]  write_reg_e;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] alu_out_m;
  logic        reg_write_m;
  logic [4:0]  write_reg_m;
  logic        mem_to_reg_m;
  logic        stall_m;
  logic        reg_write_w;
  logic [4:0]  write_reg_w;
  logic [31:0] result_w;
  logic        misalign, bus_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_writeback #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .reg_write_e_i  (reg_write_e),
    .mem_write_e_i  (mem_write_e),
    .mem_to_reg_e_i (mem_to_reg_e),
    .alu_out_e_i    (alu_out_e),
    .write_data_e_i (write_data_e),
    .write_reg_e_i  (write_reg_e),
    .dmem_req_o     (dmem_req),
    .dmem_we_o      (dmem_we),
    .dmem_addr_o    (dmem_addr),
    .dmem_wdata_o   (dmem_wdata),
    .dmem_ack_i     (dmem_ack),
    .dmem_rdata_i   (dmem_rdata),
    .alu_out_m_o    (alu_out_m),
    .reg_write_m_o  (reg_write_m),
    .write_reg_m_o  (write_reg_m),
    .mem_to_reg_m_o (mem_to_reg_m),
    .stall_m_o      (stall_m),
    .reg_write_w_o  (reg_write_w),
    .write_reg_w_o  (write_reg_w),
    .result_w_o     (result_w),
    .misalign_o     (misalign),
    .bus_err_o      (bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_e(input logic rw, input logic mw, input logic m2r,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr);
    reg_write_e  = rw;
    mem_write_e  = mw;
    mem_to_reg_e = m2r;
    alu_out_e    = alu;
    write_data_e = wd;
    write_reg_e  = wr;
  endtask

  initial begin
    rst = 1'b1;
    set_e(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31);
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;

    // Reset state
    tick();
    set_e(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    tick();
    settle();
    chk("rst_req", dmem_req, 0);
    chk("rst_stall", stall_m, 0);
    chk("rst_reg_write_w", reg_write_w, 0);
    chk("rst_result_w", result_w, 0);
    chk("rst_alu_out_m", alu_out_m, 0);
    chk("rst_misalign", misalign, 0);
    chk("rst_bus_err", bus_err, 0);
    rst = 1'b0;

    // ALU op passes through in two edges
    set_e(1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 5'd5);
    tick();
    settle();
    chk("alu_stall", stall_m, 0);
    chk("alu_m_alu", alu_out_m, 32'h1234);
    chk("alu_m_wr", write_reg_m, 5);
    set_e(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    tick();
    settle();
    chk("alu_w_rw", reg_write_w, 1);
    chk("alu_w_wr", write_reg_w, 5);
    chk("alu_w_res", result_w, 32'h1234);
    chk("alu_stall2", stall_m, 0);

    // Zero-wait load
    set_e(1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 5'd7);
    tick();
    set_e(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    dmem_ack = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    settle();
    chk("zw_req", dmem_req, 1);
    chk("zw_we", dmem_we, 0);
    chk("zw_addr", dmem_addr, 32'h100);
    chk("zw_stall", stall_m, 0);
    tick();
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    settle();
    chk("zw_w_rw", reg_write_w, 1);
    chk("zw_w_res", result_w, 32'hDEAD_BEEF);
    chk("zw_w_wr", write_reg_w, 7);
    chk("zw_req_after", dmem_req, 0);

    // Load with 3 stall cycles
    set_e(1'b1, 1'b0, 1'b1, 32'h200, 32'h0, 5'd9);
    tick();
    set_e(1'b1, 1'b0, 1'b0, 32'h55, 32'h0, 5'd3);
    settle();
    chk("w3_stall0", stall_m, 1);
    chk("w3_addr0", dmem_addr, 32'h200);
    tick();
    settle();
    chk("w3_stall1", stall_m, 1);
    chk("w3_hold_m", alu_out_m, 32'h200);
    chk("w3_bubble1", reg_write_w, 0);
    tick();
    settle();
    chk("w3_stall2", stall_m, 1);
    chk("w3_addr2", dmem_addr, 32'h200);
    chk("w3_bubble2", reg_write_w, 0);
    tick();
    dmem_ack = 1'b1;
    dmem_rdata = 32'hCAFE_F00D;
    settle();
    chk("w3_ack_stall", stall_m, 0);
    chk("w3_ack_bus_err", bus_err, 0);
    chk("w3_bubble3", reg_write_w, 0);
    tick();
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    set_e(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    settle();
    chk("w3_w_rw", reg_write_w, 1);
    chk("w3_w_res", result_w, 32'hCAFE_F00D);
    chk("w3_w_wr", write_reg_w, 9);
    chk("w3_m_adv", alu_out_m, 32'h55);
    chk("w3_req_off", dmem_req, 0);
    tick();
    settle();
    chk("w3_next_wr", write_reg_w, 3);
    chk("w3_next_res", result_w, 32'h55);

    // Misaligned store
    set_e(1'b0, 1'b1, 1'b0, 32'h202, 32'hAA, 5'd0);
    tick();
    set_e(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    settle();
    chk("mis_req", dmem_req, 0);
    chk("mis_pulse", misalign, 1);
    chk("mis_stall", stall_m, 0);
    tick();
    settle();
    chk("mis_pulse_end", misalign, 0);
    chk("mis_w_rw", reg_write_w, 0);

    // Aligned store with reg_write wrongly set never writes the register file
    set_e(1'b1, 1'b1, 1'b0, 32'h300, 32'h77, 5'd4);
    tick();
    set_e(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    dmem_ack = 1'b1;
    settle();
    chk("st_req", dmem_req, 1);
    chk("st_we", dmem_we, 1);
    chk("st_wdata", dmem_wdata, 32'h77);
    chk("st_stall", stall_m, 0);
    tick();
    dmem_ack = 1'b0;
    settle();
    chk("st_w_rw", reg_write_w, 0);

    // Timeout with TIMEOUT_CYCLES = 4
    set_e(1'b1, 1'b0, 1'b1, 32'h400, 32'h0, 5'd6);
    tick();
    set_e(1'b1, 1'b0, 1'b0, 32'h66, 32'h0, 5'd2);
    for (int i = 0; i < 4; i++) begin
      settle();
      chk($sformatf("to_stall%0d", i), stall_m, 1);
      chk($sformatf("to_no_err%0d", i), bus_err, 0);
      tick();
    end
    settle();
    chk("to_abort_stall", stall_m, 0);
    chk("to_bus_err", bus_err, 1);
    tick();
    set_e(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    settle();
    chk("to_bus_err_end", bus_err, 0);
    chk("to_w_bubble", reg_write_w, 0);
    chk("to_m_adv", alu_out_m, 32'h66);
    tick();
    settle();
    chk("to_resume_rw", reg_write_w, 1);
    chk("to_resume_res", result_w, 32'h66);

    // Reset in the second WAIT cycle, then a late ack
    set_e(1'b1, 1'b0, 1'b1, 32'h500, 32'h0, 5'd8);
    tick();
    set_e(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    settle();
    chk("rw_stall_idle", stall_m, 1);
    tick();
    tick();
    settle();
    chk("rw_stall_wait2", stall_m, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk("rw_req", dmem_req, 0);
    chk("rw_stall", stall_m, 0);
    chk("rw_rw", reg_write_w, 0);
    chk("rw_res", result_w, 0);
    chk("rw_alu_m", alu_out_m, 0);
    chk("rw_rwm", reg_write_m, 0);
    chk("rw_err", bus_err | misalign, 0);
    dmem_ack = 1'b1;
    dmem_rdata = 32'h1234_5678;
    tick();
    dmem_ack = 1'b0;
    settle();
    chk("rw_late_ack_rw", reg_write_w, 0);
    chk("rw_late_ack_res", result_w, 0);
    chk("rw_late_req", dmem_req, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
